laplacian_conv_ctrl: RTL and testbench

Sequencer for the Laplacian 3x3 convolution datapath (line buffer feeding the multiply stage, then adder stages 1-3). Walks a raster image one pixel at a time and marks which accepted pixels complete a valid 3x3 window. Fires the per-stage enable pulses through the pipeline and produces the output write strobe and address. Reports busy/done to the top-level layer controller.

---
 rtl/laplacian_conv_ctrl.sv | 165 ++++++++++++++++
 tb/tb_laplacian_conv_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laplacian_conv_ctrl.sv
// rtl/laplacian_conv_ctrl.sv - raster sequencer and stage-enable pipeline for the 3x3 Laplacian convolution datapath
//
// Walks an IMG_W x IMG_H raster one accepted pixel at a time. It tags each pixel
// that completes a full 3x3 window and shifts that tag through a PIPE_DEPTH+1 bit
// enable pipeline. The pipeline drives the per-stage enables and the result write strobe.
//
// Optional feature macro: LAPLACE_CTRL_PERF_EN (adds the stall_cnt output).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   frame start pulse, honoured in IDLE only
//   pix_valid  in   pixel at pix_addr is presented this cycle
//   pix_addr   out  raster index of the next pixel to accept
//   rd_en      out  high in RUN; pixel source may present data
//   stage_en   out  per-stage enables, bit 0 = multiply stage
//   wr_en      out  final adder output valid
//   wr_addr    out  result index of the current write
//   busy       out  high in RUN and DRAIN
//   done       out  one-cycle pulse at frame completion
//   stall_cnt  out  (LAPLACE_CTRL_PERF_EN only) RUN cycles without a pixel, saturating

module laplacian_conv_ctrl #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int ADDR_W     = 10,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pix_valid,
  output logic [ADDR_W-1:0]     pix_addr,
  output logic                  rd_en,
  output logic [PIPE_DEPTH-1:0] stage_en,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  busy,
`ifdef LAPLACE_CTRL_PERF_EN
  output logic                  done,
  output logic [15:0]           stall_cnt
`else
  output logic                  done
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [PIPE_DEPTH:0] pipe;   // [PIPE_DEPTH-1:0] = stage enables, [PIPE_DEPTH] = write tap
  logic                accept;
  logic                last_pix;
  logic                win;
  logic                frame_start;

  assign frame_start = (state == S_IDLE) && start;
  assign accept      = (state == S_RUN) && pix_valid;
  assign last_pix    = (row == ROW_LAST) && (col == COL_LAST);
  // A pixel closes a 3x3 window once two full rows and two columns precede it.
  assign win         = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
      // The write tap is part of pipe, so the last write has left before DONE.
      S_DRAIN: if (pipe == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_addr <= '0;
      col      <= '0;
      row      <= '0;
    end else if (frame_start) begin
      pix_addr <= '0;
      col      <= '0;
      row      <= '0;
    end else if (accept) begin
      // Hold pix_addr and row on the final pixel so they never step past the frame.
      if (!last_pix) begin
        pix_addr <= pix_addr + ADDR_W'(1);
      end
      if (col == COL_LAST) begin
        col <= '0;
        if (!last_pix) begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Enable pipeline: a zero enters on every non-window or stalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else if ((state == S_RUN) || (state == S_DRAIN)) begin
      pipe <= {pipe[PIPE_DEPTH-1:0], accept && win};
    end else begin
      pipe <= '0;
    end
  end

  // Result address advances after each write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
    end else if (frame_start) begin
      wr_addr <= '0;
    end else if (pipe[PIPE_DEPTH]) begin
      wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

`ifdef LAPLACE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (frame_start) begin
      stall_cnt <= '0;
    end else if ((state == S_RUN) && !pix_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  // All outputs decode registers only; inputs never reach them combinationally.
  assign stage_en = pipe[PIPE_DEPTH-1:0];
  assign wr_en    = pipe[PIPE_DEPTH];
  assign rd_en    = (state == S_RUN);
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_laplacian_conv_ctrl.sv
// tb/tb_laplacian_conv_ctrl.sv - directed self-checking bench for laplacian_conv_ctrl

module tb_laplacian_conv_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int AW = 10;
  localparam int PD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_b = 1'b0;
  logic pix_valid = 1'b0;

  logic [AW-1:0] pix_addr, wr_addr, pix_addr_b, wr_addr_b;
  logic [PD-1:0] stage_en, stage_en_b;
  logic rd_en, wr_en, busy, done, rd_en_b, wr_en_b, busy_b, done_b;
`ifdef LAPLACE_CTRL_PERF_EN
  logic [15:0] stall_cnt, stall_cnt_b;
`endif

  laplacian_conv_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_addr(pix_addr), .rd_en(rd_en), .stage_en(stage_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy),
`ifdef LAPLACE_CTRL_PERF_EN
    .done(done), .stall_cnt(stall_cnt)
`else
    .done(done)
`endif
  );

  laplacian_conv_ctrl dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pix_valid(pix_valid),
    .pix_addr(pix_addr_b), .rd_en(rd_en_b), .stage_en(stage_en_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .busy(busy_b),
`ifdef LAPLACE_CTRL_PERF_EN
    .done(done_b), .stall_cnt(stall_cnt_b)
`else
    .done(done_b)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; monitors sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Small-geometry monitor with an independent window-timing model.
  int cyc = 0;
  bit ring[16];
  logic [PD:0] exp_pipe;
  int wr_cnt, wr_seq_err, done_cnt, done_cyc, last_wr_cyc, first_wr_cyc, acc12_cyc;
  int stage_mis, busy_at_done, busy_before, idle_act;
  logic prev_busy = 1'b0;
  logic acc;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ring[i] = 1'b0;
      prev_busy = 1'b0;
    end else begin
      for (int k = 0; k <= PD; k++) exp_pipe[k] = ring[(cyc - 1 - k) & 15];
      if ({wr_en, stage_en} !== exp_pipe) stage_mis++;
      acc = rd_en && pix_valid;
      ring[cyc & 15] = acc && (int'(pix_addr) / W >= 2) && (int'(pix_addr) % W >= 2);
      if (acc && pix_addr == 12) acc12_cyc = cyc;
      if (wr_en) begin
        if (int'(wr_addr) != wr_cnt) wr_seq_err++;
        if (wr_cnt == 0) first_wr_cyc = cyc;
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = int'(busy);
        busy_before = int'(prev_busy);
      end
      if (!busy && (stage_en != '0 || wr_en)) idle_act++;
      prev_busy = busy;
    end
  end

  // Default-geometry monitor.
  int wr_cnt_b, last_addr_b, done_cnt_b, done_run_b, done_w_max_b, busy_fall_ok_b;
  logic prev_busy_b = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_b) begin
        wr_cnt_b++;
        last_addr_b = int'(wr_addr_b);
      end
      if (done_b) begin
        if (done_run_b == 0) begin
          done_cnt_b++;
          if (!busy_b && prev_busy_b) busy_fall_ok_b++;
        end
        done_run_b++;
        if (done_run_b > done_w_max_b) done_w_max_b = done_run_b;
      end else begin
        done_run_b = 0;
      end
      prev_busy_b = busy_b;
    end
  end

  task automatic clear_mon();
    wr_cnt = 0; wr_seq_err = 0; done_cnt = 0; done_cyc = 0; last_wr_cyc = 0;
    first_wr_cyc = 0; acc12_cyc = -100; stage_mis = 0; busy_at_done = -1;
    busy_before = -1; idle_act = 0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt > 0), 32'd1);
  endtask

  initial begin
    clear_mon();
    wr_cnt_b = 0; last_addr_b = -1; done_cnt_b = 0; done_run_b = 0;
    done_w_max_b = 0; busy_fall_ok_b = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_pix_addr", 32'(pix_addr), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_stage_en", 32'(stage_en), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Idle with pix_valid and no start
    pix_valid = 1'b1;
    repeat (8) tick();
    chk("idle_pix_addr", 32'(pix_addr), 32'd0);
    chk("idle_activity", 32'(idle_act), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Continuous 5x4 frame
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t1_done_seen", 200);
    repeat (3) tick();
    chk("t1_writes", 32'(wr_cnt), 32'd6);
    chk("t1_wr_addr_seq", 32'(wr_seq_err), 32'd0);
    chk("t1_first_wr_lat", 32'(first_wr_cyc - acc12_cyc), 32'd5);
    chk("t1_done_after_last_wr", 32'(done_cyc - last_wr_cyc), 32'd2);
    chk("t1_done_count", 32'(done_cnt), 32'd1);
    chk("t1_stage_timing", 32'(stage_mis), 32'd0);
    chk("t1_busy_at_done", 32'(busy_at_done), 32'd0);
    chk("t1_busy_before_done", 32'(busy_before), 32'd1);
    chk("t1_last_pix_addr", 32'(pix_addr), 32'd19);

    // Toggling pix_valid 1,0,1,0
    clear_mon();
    pix_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1;
    for (int n = 0; n < 200 && done_cnt == 0; n++) begin
      tick();
      pix_valid = ~pix_valid;
    end
    chk("t2_done_seen", 32'(done_cnt > 0), 32'd1);
    pix_valid = 1'b1;
    repeat (3) tick();
    chk("t2_writes", 32'(wr_cnt), 32'd6);
    chk("t2_wr_addr_seq", 32'(wr_seq_err), 32'd0);
    chk("t2_stage_timing", 32'(stage_mis), 32'd0);
    chk("t2_done_count", 32'(done_cnt), 32'd1);
`ifdef LAPLACE_CTRL_PERF_EN
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd19);
    repeat (4) tick();
    chk("t2_stall_cnt_hold", 32'(stall_cnt), 32'd19);
`endif

    // Start pulsed mid-RUN at pix_addr 7
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 50 && pix_addr != 7; n++) tick();
    chk("t3_reached_7", 32'(pix_addr), 32'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_addr_after_start", 32'(pix_addr), 32'd8);
    wait_done("t3_done_seen", 200);
    repeat (5) tick();
    chk("t3_writes", 32'(wr_cnt), 32'd6);
    chk("t3_wr_addr_seq", 32'(wr_seq_err), 32'd0);
    chk("t3_done_count", 32'(done_cnt), 32'd1);
    chk("t3_stage_timing", 32'(stage_mis), 32'd0);

    // Asynchronous reset mid-frame at pix_addr 10
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 50 && pix_addr != 10; n++) tick();
    chk("t4_reached_10", 32'(pix_addr), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_pix_addr", 32'(pix_addr), 32'd0);
    chk("t4_async_rd_en", 32'(rd_en), 32'd0);
    chk("t4_async_busy", 32'(busy), 32'd0);
    chk("t4_async_outs", 32'({stage_en, wr_en, done, wr_addr}), 32'd0);
    repeat (3) tick();
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4_done_seen", 200);
    repeat (3) tick();
    chk("t4_writes", 32'(wr_cnt), 32'd6);
    chk("t4_wr_addr_seq", 32'(wr_seq_err), 32'd0);
    chk("t4_done_count", 32'(done_cnt), 32'd1);
    chk("t4_stage_timing", 32'(stage_mis), 32'd0);

    // Default 28x28 frame, continuous; small instance left idle with pix_valid high
    idle_act = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 0; n < 1500 && done_cnt_b == 0; n++) tick();
    chk("t5_done_seen", 32'(done_cnt_b > 0), 32'd1);
    repeat (4) tick();
    chk("t5_writes", 32'(wr_cnt_b), 32'd676);
    chk("t5_final_wr_addr", 32'(last_addr_b), 32'd675);
    chk("t5_done_count", 32'(done_cnt_b), 32'd1);
    chk("t5_done_width", 32'(done_w_max_b), 32'd1);
    chk("t5_busy_falls_with_done", 32'(busy_fall_ok_b), 32'd1);
    chk("t5_small_idle_activity", 32'(idle_act), 32'd0);
    chk("t5_small_pix_addr_held", 32'(pix_addr), 32'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
